piso_serializer_8_bit: RTL and testbench
========================================

PISO_SERIALIZER_8_BIT -- requirements
Module: piso_serializer_8_bit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of bits per frame.
REQ-002 SHALL have parameter LSB_FIRST, default 1; 1 = bit 0 transmitted first, 0 = MSB first.
REQ-003 Clk_In  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_N_In  input  1  reset, asynchronous assert, active-low.
REQ-005 Parallel_Data_In  input  DATA_WIDTH  word to serialize.
REQ-006 Data_Valid_In  input  1  Parallel_Data_In valid.
REQ-007 Data_Ready_Out  output  1  block accepts a word this cycle.
REQ-008 Serial_Data_Out  output  1  serial bit stream, to the SIPO Serial_Data_In.
REQ-009 Serial_Valid_Out  output  1  high during every cycle carrying a frame bit.
REQ-010 Frame_Done_Out  output  1  one-cycle pulse during the last bit of a frame.

Function
REQ-011 SHALL implement FSM with states IDLE and SHIFT, plus down/up bit counter 0..DATA_WIDTH-1.
REQ-012 Transfer SHALL occur on a rising edge where Data_Valid_In and Data_Ready_Out are both 1; word latched into internal shift register, counter cleared, state -> SHIFT.
REQ-013 Data_Ready_Out SHALL be 1 in IDLE, 0 in SHIFT (except REQ-022); it SHALL depend only on registered state, never combinationally on Data_Valid_In.
REQ-014 In SHIFT, Serial_Data_Out SHALL present one bit per cycle, order per LSB_FIRST; first bit visible in the cycle after the transfer edge (latency 1).
REQ-015 All outputs SHALL change only on rising edges, so data is stable at the falling edge used by the downstream SIPO.
REQ-016 Frame_Done_Out SHALL be 1 exactly in the cycle where counter = DATA_WIDTH-1.
REQ-017 After last bit, without new transfer, state -> IDLE; Serial_Valid_Out = 0, Serial_Data_Out = 0.
REQ-018 In IDLE, Serial_Data_Out SHALL be driven 0 and Serial_Valid_Out 0.
REQ-019 Data_Valid_In while Data_Ready_Out = 0 SHALL be ignored; Parallel_Data_In changes mid-frame SHALL not affect the frame in flight.
REQ-020 Counter SHALL wrap DATA_WIDTH-1 -> 0 only on a new transfer; no other wrap.

Reset
REQ-021 Reset_N_In low SHALL immediately force IDLE, counter 0, shift register 0, Data_Ready_Out 1, Serial_Data_Out 0, Serial_Valid_Out 0, Frame_Done_Out 0; a frame in progress is aborted with no Frame_Done_Out; deassertion resumes at next rising edge.

Configuration
REQ-022 Macro PISO_BACK_TO_BACK_EN: when defined, Data_Ready_Out SHALL also be 1 in the last-bit cycle; a transfer there loads the new word and stays in SHIFT, giving continuous DATA_WIDTH-cycle frames with no gap; when undefined, minimum frame period is DATA_WIDTH+1 cycles (one IDLE cycle between frames).

Structure
REQ-023 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the default width constant (8).
REQ-024 Bit counter SHALL be a sub-module piso_bit_counter (clear, enable, terminal-count output).

Verification
REQ-025 Reset mid-frame: transfer 0xFF, assert Reset_N_In low after 3 bits -> all outputs at reset values same cycle, no Frame_Done_Out, Data_Ready_Out 1 after release.
REQ-026 Single word: transfer 0xA5, LSB_FIRST=1 -> Serial_Data_Out 1,0,1,0,0,1,0,1 on cycles 1..8; Frame_Done_Out on cycle 8; Serial_Valid_Out high cycles 1..8 only.
REQ-027 Loopback into SIPO (8-bit, falling-edge, shifts toward bit 0): transfer 0x3C -> SIPO register = 0x3C after the 8th falling edge.
REQ-028 Backpressure: hold Data_Valid_In=1 with 0x11 then 0x22 -> second word accepted only when Data_Ready_Out=1; period 9 cycles without macro, 8 cycles with PISO_BACK_TO_BACK_EN, no bit lost or duplicated.
REQ-029 Input change mid-frame: transfer 0x0F, change Parallel_Data_In to 0xF0 at bit 2 -> output stream remains 0x0F.
REQ-030 LSB_FIRST=0: transfer 0x80 -> Serial_Data_Out 1 on cycle 1, 0 on cycles 2..8.

Source files
------------

// File: rtl/piso_serializer_8_bit_pkg.sv
// Shared types and constants for the PISO serializer and its bit counter.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Counter width for a 0..w-1 bit index.
  function automatic int piso_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_8_bit_if.sv
// Parallel-in handshake and serial-out bus of the PISO serializer.
interface piso_serializer_8_bit_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Parallel_Data_In;
  logic                  Data_Valid_In;
  logic                  Data_Ready_Out;
  logic                  Serial_Data_Out;
  logic                  Serial_Valid_Out;
  logic                  Frame_Done_Out;

  modport master (
    output Parallel_Data_In, Data_Valid_In,
    input  Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Frame_Done_Out
  );

  modport slave (
    input  Parallel_Data_In, Data_Valid_In,
    output Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Frame_Done_Out
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Bit index counter 0..MAX_COUNT-1: clear has priority, holds at terminal count.
module piso_bit_counter #(
  parameter int MAX_COUNT = 8,
  parameter int CW        = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Only a clear returns to 0; the count never wraps on its own.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/piso_serializer_8_bit.sv
// Parallel-in serial-out serializer, one bit per cycle, registered outputs only.
// Optional macro PISO_BACK_TO_BACK_EN accepts the next word during the last bit.
module piso_serializer_8_bit
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = PISO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                   Clk_In,
  input  logic                   Reset_N_In,
  piso_serializer_8_bit_if.slave bus
);
  localparam int CW = piso_cnt_w(DATA_WIDTH);

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  cnt_clr, cnt_en, cnt_tc;
  logic                  last_bit, ready, xfer;

  assign last_bit = (state_q == SHIFT) && cnt_tc;

`ifdef PISO_BACK_TO_BACK_EN
  assign ready = (state_q == IDLE) || last_bit;
`else
  assign ready = (state_q == IDLE);
`endif

  assign xfer = bus.Data_Valid_In && ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          shift_d = bus.Parallel_Data_In;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (xfer) begin
          shift_d = bus.Parallel_Data_In;
          cnt_clr = 1'b1;
        end else if (last_bit) begin
          state_d = IDLE;
          shift_d = '0;
        end else begin
          cnt_en  = 1'b1;
          shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  piso_bit_counter #(
    .MAX_COUNT (DATA_WIDTH),
    .CW        (CW)
  ) u_cnt (
    .clk   (Clk_In),
    .rst_n (Reset_N_In),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // Outputs decode flops only, so they move on rising edges alone.
  assign bus.Data_Ready_Out   = ready;
  assign bus.Serial_Valid_Out = (state_q == SHIFT);
  assign bus.Serial_Data_Out  = (state_q == SHIFT) &&
                                (LSB_FIRST ? shift_q[0] : shift_q[DATA_WIDTH-1]);
  assign bus.Frame_Done_Out   = last_bit;
endmodule

// File: tb/tb_piso_serializer_8_bit.sv
// Directed self-checking bench: an LSB-first and an MSB-first serializer, plus a falling-edge SIPO model.
module tb_piso_serializer_8_bit;
  logic Clk_In;
  logic Reset_N_In;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] sipo = '0;

  piso_serializer_8_bit_if #(.DATA_WIDTH(8)) bus_l ();
  piso_serializer_8_bit_if #(.DATA_WIDTH(8)) bus_m ();

  piso_serializer_8_bit #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .Clk_In     (Clk_In),
    .Reset_N_In (Reset_N_In),
    .bus        (bus_l)
  );

  piso_serializer_8_bit #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .Clk_In     (Clk_In),
    .Reset_N_In (Reset_N_In),
    .bus        (bus_m)
  );

  initial begin
    Clk_In = 1'b0;
    forever #5 Clk_In = ~Clk_In;
  end

  // Downstream receiver: samples on the falling edge, new bit enters at the MSB.
  always @(negedge Clk_In)
    if (bus_l.Serial_Valid_Out) sipo <= {bus_l.Serial_Data_Out, sipo[7:1]};

`ifdef PISO_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  task automatic send_l(input logic [7:0] d);
    @(posedge Clk_In); #1;
    bus_l.Data_Valid_In    = 1'b1;
    bus_l.Parallel_Data_In = d;
    @(posedge Clk_In); #1;
    bus_l.Data_Valid_In    = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (bus_l.Data_Ready_Out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus_l.Data_Ready_Out); end
    n_checks++; if (bus_l.Serial_Data_Out !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got %b want 0", bus_l.Serial_Data_Out); end
    n_checks++; if (bus_l.Serial_Valid_Out !== 1'b0) begin n_fail++; $display("FAIL reset_sv got %b want 0", bus_l.Serial_Valid_Out); end
    n_checks++; if (bus_l.Frame_Done_Out !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", bus_l.Frame_Done_Out); end
    @(negedge Clk_In); Reset_N_In = 1'b1;
    @(negedge Clk_In);
    n_checks++; if (bus_l.Data_Ready_Out !== 1'b1 || bus_l.Serial_Valid_Out !== 1'b0) begin
      n_fail++; $display("FAIL reset_release ready=%b sv=%b want 1/0", bus_l.Data_Ready_Out, bus_l.Serial_Valid_Out);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    exp = 8'hA5;
    send_l(8'hA5);
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk_In);
      n_checks++; if (bus_l.Serial_Data_Out !== exp[i-1]) begin n_fail++; $display("FAIL single_bit%0d got %b want %b", i, bus_l.Serial_Data_Out, exp[i-1]); end
      n_checks++; if (bus_l.Serial_Valid_Out !== 1'b1) begin n_fail++; $display("FAIL single_sv%0d got %b want 1", i, bus_l.Serial_Valid_Out); end
      n_checks++; if (bus_l.Frame_Done_Out !== (i == 8)) begin n_fail++; $display("FAIL single_fd%0d got %b want %b", i, bus_l.Frame_Done_Out, (i == 8)); end
      n_checks++; if (bus_l.Data_Ready_Out !== ((i == 8) && BTB)) begin n_fail++; $display("FAIL single_ready%0d got %b want %b", i, bus_l.Data_Ready_Out, ((i == 8) && BTB)); end
    end
    @(negedge Clk_In);
    n_checks++; if ({bus_l.Serial_Valid_Out, bus_l.Serial_Data_Out, bus_l.Frame_Done_Out, bus_l.Data_Ready_Out} !== 4'b0001) begin
      n_fail++; $display("FAIL single_idle sv/sdo/fd/ready got %b%b%b%b want 0001", bus_l.Serial_Valid_Out, bus_l.Serial_Data_Out, bus_l.Frame_Done_Out, bus_l.Data_Ready_Out);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_l(8'hFF);
    repeat (3) @(negedge Clk_In);
    n_checks++; if (bus_l.Serial_Data_Out !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit3 got %b want 1", bus_l.Serial_Data_Out); end
    @(posedge Clk_In); #2;
    Reset_N_In = 1'b0;
    #1;
    n_checks++; if ({bus_l.Data_Ready_Out, bus_l.Serial_Data_Out, bus_l.Serial_Valid_Out, bus_l.Frame_Done_Out} !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_outputs ready/sdo/sv/fd got %b%b%b%b want 1000", bus_l.Data_Ready_Out, bus_l.Serial_Data_Out, bus_l.Serial_Valid_Out, bus_l.Frame_Done_Out);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk_In);
      if (i == 3) Reset_N_In = 1'b1;
      n_checks++; if (bus_l.Frame_Done_Out !== 1'b0 || bus_l.Serial_Valid_Out !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_abort%0d fd=%b sv=%b want 0/0", i, bus_l.Frame_Done_Out, bus_l.Serial_Valid_Out);
      end
    end
    n_checks++; if (bus_l.Data_Ready_Out !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", bus_l.Data_Ready_Out); end
  endtask

  task automatic test_sipo_loopback();
    send_l(8'h3C);
    repeat (8) @(negedge Clk_In);
    n_checks++; if (bus_l.Frame_Done_Out !== 1'b1) begin n_fail++; $display("FAIL loop_fd got %b want 1", bus_l.Frame_Done_Out); end
    #1;
    n_checks++; if (sipo !== 8'h3C) begin n_fail++; $display("FAIL loop_sipo got %h want 3c", sipo); end
    @(negedge Clk_In);
  endtask

  task automatic test_backpressure();
    logic [15:0] stream;
    int nb, fd1, fd2, acc_cyc;
    logic acc;
    stream = '0; nb = 0; fd1 = -1; fd2 = -1; acc_cyc = -1;
    @(posedge Clk_In); #1;
    bus_l.Data_Valid_In = 1'b1; bus_l.Parallel_Data_In = 8'h11;
    @(posedge Clk_In); #1;
    bus_l.Parallel_Data_In = 8'h22;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk_In);
      if (bus_l.Serial_Valid_Out) begin
        if (nb < 16) stream[nb] = bus_l.Serial_Data_Out;
        nb++;
      end
      if (bus_l.Frame_Done_Out) begin
        if (fd1 < 0) fd1 = c; else if (fd2 < 0) fd2 = c;
      end
      acc = bus_l.Data_Ready_Out && bus_l.Data_Valid_In;
      if (acc) acc_cyc = c;
      @(posedge Clk_In); #1;
      if (acc) bus_l.Data_Valid_In = 1'b0;
    end
    n_checks++; if (stream !== 16'h2211) begin n_fail++; $display("FAIL bp_stream got %h want 2211", stream); end
    n_checks++; if (nb != 16) begin n_fail++; $display("FAIL bp_bitcount got %0d want 16", nb); end
    n_checks++; if (acc_cyc != (BTB ? 8 : 9)) begin n_fail++; $display("FAIL bp_accept_cycle got %0d want %0d", acc_cyc, (BTB ? 8 : 9)); end
    n_checks++; if (fd1 != 8) begin n_fail++; $display("FAIL bp_fd1 got %0d want 8", fd1); end
    n_checks++; if (fd2 != (BTB ? 16 : 17)) begin n_fail++; $display("FAIL bp_fd2 got %0d want %0d", fd2, (BTB ? 16 : 17)); end
  endtask

  task automatic test_input_change();
    logic [7:0] got;
    got = '0;
    send_l(8'h0F);
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk_In);
      got[i-1] = bus_l.Serial_Data_Out;
      if (i == 2) begin bus_l.Parallel_Data_In = 8'hF0; bus_l.Data_Valid_In = 1'b1; end
      if (i == 4) bus_l.Data_Valid_In = 1'b0;
    end
    n_checks++; if (got !== 8'h0F) begin n_fail++; $display("FAIL chg_stream got %h want 0f", got); end
    @(negedge Clk_In);
    n_checks++; if (bus_l.Serial_Valid_Out !== 1'b0) begin n_fail++; $display("FAIL chg_no_restart sv got %b want 0", bus_l.Serial_Valid_Out); end
  endtask

  task automatic test_msb_first();
    @(posedge Clk_In); #1;
    bus_m.Data_Valid_In = 1'b1; bus_m.Parallel_Data_In = 8'h80;
    @(posedge Clk_In); #1;
    bus_m.Data_Valid_In = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk_In);
      n_checks++; if (bus_m.Serial_Data_Out !== (i == 1)) begin n_fail++; $display("FAIL msb_bit%0d got %b want %b", i, bus_m.Serial_Data_Out, (i == 1)); end
      n_checks++; if (bus_m.Serial_Valid_Out !== 1'b1) begin n_fail++; $display("FAIL msb_sv%0d got %b want 1", i, bus_m.Serial_Valid_Out); end
    end
    n_checks++; if (bus_m.Frame_Done_Out !== 1'b1) begin n_fail++; $display("FAIL msb_fd got %b want 1", bus_m.Frame_Done_Out); end
    @(negedge Clk_In);
    n_checks++; if (bus_m.Serial_Valid_Out !== 1'b0 || bus_m.Data_Ready_Out !== 1'b1) begin
      n_fail++; $display("FAIL msb_idle sv=%b ready=%b want 0/1", bus_m.Serial_Valid_Out, bus_m.Data_Ready_Out);
    end
  endtask

  initial begin
    Reset_N_In             = 1'b0;
    bus_l.Data_Valid_In    = 1'b0;
    bus_l.Parallel_Data_In = '0;
    bus_m.Data_Valid_In    = 1'b0;
    bus_m.Parallel_Data_In = '0;
    test_reset();
    test_single_word();
    test_reset_mid_frame();
    test_sipo_loopback();
    test_backpressure();
    test_input_change();
    test_msb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
